// File: rtl/store_buffer_bridge_if.sv
// Core data-memory port and data_mem RAM port of the store buffer bridge.
// The bridge takes the slave side; the core/RAM environment takes the master side.
interface store_buffer_bridge_if #(parameter int AW = 32);
    logic          cpu_en;
    logic [3:0]    cpu_wen;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;
    logic          ram_en;
    logic [3:0]    ram_wen;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic          buf_empty;

    modport slave (
        input  cpu_en, cpu_wen, cpu_addr, cpu_wdata, ram_rdata,
        output cpu_rdata, cpu_stall, ram_en, ram_wen, ram_addr, ram_wdata, buf_empty
    );

    modport master (
        output cpu_en, cpu_wen, cpu_addr, cpu_wdata, ram_rdata,
        input  cpu_rdata, cpu_stall, ram_en, ram_wen, ram_addr, ram_wdata, buf_empty
    );
endinterface

// File: rtl/store_buffer_bridge.sv
// Posted-store FIFO between the core data port and the single-ported data RAM.
// Loads bypass the FIFO unless they hit a buffered word; stores drain when the port is free.
module store_buffer_bridge #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    store_buffer_bridge_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-3:0] ent_addr  [DEPTH];
    logic [3:0]    ent_wen   [DEPTH];
    logic [31:0]   ent_wdata [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic [PW-1:0] rel [DEPTH];
    logic          load;
    logic          store;
    logic          hit;
    logic          full;
    logic          grant;
    logic          drain;
    logic          enq;

    // Requests are ignored while reset is held so the RAM port stays quiet.
    assign load  = ~rst & bus.cpu_en & (bus.cpu_wen == 4'h0);
    assign store = ~rst & bus.cpu_en & (bus.cpu_wen != 4'h0);
    assign full  = (count == CW'(DEPTH));

    // An entry is valid when its distance from head is below count.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rel[i] = PW'(i) - head;
            if (({1'b0, rel[i]} < count) && (ent_addr[i] == bus.cpu_addr[AW-1:2]))
                hit = 1'b1;
        end
    end

    assign grant = load & ~hit;
    assign drain = (count != '0) & ~grant;
    assign enq   = store & ~full;

    assign bus.cpu_stall = (load & hit) | (store & full);
    assign bus.cpu_rdata = bus.ram_rdata;
    assign bus.buf_empty = (count == '0);

    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_wen   = 4'h0;
        bus.ram_addr  = bus.cpu_addr;
        bus.ram_wdata = ent_wdata[head];
        if (grant) begin
            bus.ram_en = 1'b1;
        end else if (drain) begin
            bus.ram_en   = 1'b1;
            bus.ram_wen  = ent_wen[head];
            bus.ram_addr = {ent_addr[head], 2'b00};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq)
                tail <= tail + 1'b1;
            if (drain)
                head <= head + 1'b1;
            case ({enq, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the entry storage has no reset; validity comes solely from head and count.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_addr[tail]  <= bus.cpu_addr[AW-1:2];
            ent_wen[tail]   <= bus.cpu_wen;
            ent_wdata[tail] <= bus.cpu_wdata;
        end
    end
endmodule

// File: tb/tb_store_buffer_bridge.sv
// Bench for store_buffer_bridge: fixed vectors, reset and order sequences, then random
// traffic checked against a queue-based model of the posted-store rules and a byte RAM.
module tb_store_buffer_bridge;
    localparam int DEPTH = 4;

    typedef struct {
        logic [29:0] waddr;
        logic [3:0]  wen;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_stall;
        logic        exp_ram_en;
        logic [3:0]  exp_ram_wen;
        logic [31:0] exp_ram_addr;
        logic        exp_empty;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    store_buffer_bridge_if #(.AW(32)) bus();
    store_buffer_bridge #(.DEPTH(DEPTH), .AW(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ram_mem [int unsigned];
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] wlog [$];
    ent_t        mq [$];

    logic        obs_stall, obs_ram_en, obs_empty;
    logic [3:0]  obs_ram_wen;
    logic [31:0] obs_ram_addr, obs_ram_wdata, obs_rdata;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] m,
                                          input logic [31:0] d);
        logic [31:0] w = old;
        for (int b = 0; b < 4; b++)
            if (m[b]) w[8*b +: 8] = d[8*b +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ram_rd(input int unsigned k);
        return ram_mem.exists(k) ? ram_mem[k] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_rd(input int unsigned k);
        return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    endfunction

    // Data RAM clocked on the falling edge, read-first.
    always @(negedge clk) begin
        int unsigned k;
        if (bus.ram_en) begin
            k = int'(bus.ram_addr[31:2]);
            bus.ram_rdata <= ram_rd(k);
            if (bus.ram_wen != 4'h0) begin
                ram_mem[k] = merge(ram_rd(k), bus.ram_wen, bus.ram_wdata);
                wlog.push_back(bus.ram_addr);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One core cycle: drive at edge+1, sample at edge+7 (after the RAM edge), compare with model.
    task automatic cycle(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] data, output logic stall);
        logic hit, ld, st, grant, drain, e_stall;
        ent_t h;
        bus.cpu_en    = en;
        bus.cpu_wen   = wen;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = data;
        #6;
        obs_stall     = bus.cpu_stall;
        obs_ram_en    = bus.ram_en;
        obs_ram_wen   = bus.ram_wen;
        obs_ram_addr  = bus.ram_addr;
        obs_ram_wdata = bus.ram_wdata;
        obs_rdata     = bus.cpu_rdata;
        obs_empty     = bus.buf_empty;

        hit = 1'b0;
        foreach (mq[i]) if (mq[i].waddr == addr[31:2]) hit = 1'b1;
        ld      = en && (wen == 4'h0);
        st      = en && (wen != 4'h0);
        grant   = ld && !hit;
        e_stall = (ld && hit) || (st && mq.size() == DEPTH);
        drain   = (mq.size() != 0) && !grant;

        check("model stall", obs_stall, e_stall);
        check("model ram_en", obs_ram_en, grant || drain);
        check("model buf_empty", obs_empty, mq.size() == 0);
        if (grant) begin
            check("model load ram_wen", obs_ram_wen, 4'h0);
            check("model load ram_addr", obs_ram_addr, addr);
            check("model load rdata", obs_rdata, ref_rd(int'(addr[31:2])));
        end else if (drain) begin
            h = mq.pop_front();
            check("model drain ram_wen", obs_ram_wen, h.wen);
            check("model drain ram_addr", obs_ram_addr, {h.waddr, 2'b00});
            check("model drain ram_wdata", obs_ram_wdata, h.data);
            ref_mem[int'(h.waddr)] = merge(ref_rd(int'(h.waddr)), h.wen, h.data);
        end else begin
            check("model idle ram_wen", obs_ram_wen, 4'h0);
        end
        if (st && !e_stall)
            mq.push_back('{addr[31:2], wen, data});
        stall = e_stall;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all();
        logic s;
        for (int i = 0; i < 20 && mq.size() != 0; i++)
            cycle(1'b0, 4'h0, 32'h0, 32'h0, s);
        check("drain finished", bus.buf_empty, 1'b1);
    endtask

    task automatic issue(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] data);
        logic s;
        int   tries = 0;
        do begin
            cycle(1'b1, wen, addr, data, s);
            tries++;
        end while (s && tries < 20);
        if (s) begin
            n_checks++;
            n_fail++;
            $display("FAIL retry budget: request %0h still stalled after %0d cycles", addr, tries);
        end
    endtask

    vec_t vecs [11];

    initial begin
        logic        s;
        logic        have_req;
        logic        r_en;
        logic [3:0]  r_wen;
        logic [31:0] r_addr, r_data;
        int          n0;
        int unsigned sel;

        vecs[0]  = '{1'b1, 4'hF, 32'h100, 32'h11223344, 1'b0, 1'b0, 4'h0, 32'h0,   1'b1, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 4'h0, 32'h0,   32'h0,        1'b0, 1'b1, 4'hF, 32'h100, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 4'hF, 32'h100, 32'hA1A1A1A1, 1'b0, 1'b0, 4'h0, 32'h0,   1'b1, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 4'hF, 32'h104, 32'hB2B2B2B2, 1'b0, 1'b1, 4'hF, 32'h100, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 4'h0, 32'h200, 32'h0,        1'b0, 1'b1, 4'h0, 32'h200, 1'b0, 1'b1, 32'hCAFEF00D};
        vecs[5]  = '{1'b0, 4'h0, 32'h0,   32'h0,        1'b0, 1'b1, 4'hF, 32'h104, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 4'h0, 32'h0,   32'h0,        1'b0, 1'b0, 4'h0, 32'h0,   1'b1, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 4'h3, 32'h104, 32'hAAAA5555, 1'b0, 1'b0, 4'h0, 32'h0,   1'b1, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 4'h0, 32'h106, 32'h0,        1'b1, 1'b1, 4'h3, 32'h104, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 4'h0, 32'h106, 32'h0,        1'b0, 1'b1, 4'h0, 32'h106, 1'b1, 1'b1, 32'hB2B25555};
        vecs[10] = '{1'b0, 4'h0, 32'h0,   32'h0,        1'b0, 1'b0, 4'h0, 32'h0,   1'b1, 1'b0, 32'h0};

        ram_mem[32'h80] = 32'hCAFEF00D;
        ref_mem[32'h80] = 32'hCAFEF00D;
        bus.ram_rdata = 32'h0;

        // Reset held for 3 cycles with a load presented: the port must stay quiet.
        bus.cpu_en = 1'b1; bus.cpu_wen = 4'h0; bus.cpu_addr = 32'h200; bus.cpu_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #6;
            check("reset buf_empty", bus.buf_empty, 1'b1);
            check("reset ram_en", bus.ram_en, 1'b0);
            check("reset cpu_stall", bus.cpu_stall, 1'b0);
        end
        bus.cpu_en = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fixed vectors: first store, load priority, load hazard.
        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].data, s);
            check($sformatf("vec%0d stall", i), obs_stall, vecs[i].exp_stall);
            check($sformatf("vec%0d ram_en", i), obs_ram_en, vecs[i].exp_ram_en);
            check($sformatf("vec%0d ram_wen", i), obs_ram_wen, vecs[i].exp_ram_wen);
            check($sformatf("vec%0d buf_empty", i), obs_empty, vecs[i].exp_empty);
            if (vecs[i].exp_ram_en)
                check($sformatf("vec%0d ram_addr", i), obs_ram_addr, vecs[i].exp_ram_addr);
            if (vecs[i].chk_rdata)
                check($sformatf("vec%0d cpu_rdata", i), obs_rdata, vecs[i].exp_rdata);
        end

        // Back-to-back stores: writes must reach the RAM in program order.
        n0 = wlog.size();
        for (int i = 0; i < 5; i++)
            issue(4'hF, 32'(i * 4), 32'h5000_0000 + 32'(i));
        drain_all();
        check("order count", wlog.size() - n0, 5);
        for (int i = 0; i < 5 && n0 + i < wlog.size(); i++)
            check($sformatf("order write%0d addr", i), wlog[n0 + i], 32'(i * 4));

        // Reset asserted between edges while a store is still pending.
        issue(4'hF, 32'h40, 32'h40404040);
        issue(4'hF, 32'h44, 32'h44444444);
        issue(4'hF, 32'h48, 32'h48484848);
        bus.cpu_en = 1'b0;
        n0 = wlog.size();
        #2;
        rst = 1'b1;
        #1;
        check("async rst ram_en", bus.ram_en, 1'b0);
        check("async rst buf_empty", bus.buf_empty, 1'b1);
        check("async rst cpu_stall", bus.cpu_stall, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        mq.delete();
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 4'h0, 32'h0, 32'h0, s);
        check("no write after rst", wlog.size() - n0, 0);
        check("lost store not written", ram_rd(32'h12), 32'h0);

        // Random interleaved stores and loads over a small window so hits and wraps are common.
        have_req = 1'b0;
        r_en = 1'b0; r_wen = 4'h0; r_addr = 32'h0; r_data = 32'h0;
        for (int n = 0; n < 400; n++) begin
            if (!have_req) begin
                sel    = $urandom_range(0, 99);
                r_addr = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
                r_data = $urandom;
                if (sel < 20) begin
                    r_en = 1'b0; r_wen = 4'h0;
                end else if (sel < 60) begin
                    r_en = 1'b1; r_wen = 4'($urandom_range(1, 15));
                end else begin
                    r_en = 1'b1; r_wen = 4'h0;
                end
            end
            cycle(r_en, r_wen, r_addr, r_data, s);
            have_req = s;
        end
        drain_all();
        foreach (ref_mem[k])
            check($sformatf("ram image word %0h", k), ram_rd(k), ref_mem[k]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
